// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU write-back stage.
//   - WBcontrols bundle bit positions
//   - halt FSM state encoding
//   - HLT opcode constant
package cpu_pkg;

  localparam int unsigned MEMTOREG_BIT = 1;
  localparam int unsigned WREN_BIT     = 0;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } wb_state_e;

  localparam logic [3:0] OP_HLT = 4'hF;

endpackage

// File: rtl/wb_pipe_reg.sv
// MEM/WB pipeline register with stall, flush and freeze.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   stall, flush        hold / invalidate control (flush wins)
//   freeze              hold everything unconditionally (processor halted)
//   in_*                MEM-stage fields to capture
//   q_*                 registered fields
module wb_pipe_reg #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  input  logic              in_mem_to_reg,
  input  logic              in_wr_en,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [3:0]        in_dst_reg,
  input  logic              in_is_halt,
  output logic              q_valid,
  output logic              q_mem_to_reg,
  output logic              q_wr_en,
  output logic [DATA_W-1:0] q_mem_data,
  output logic [DATA_W-1:0] q_alu_result,
  output logic [3:0]        q_dst_reg,
  output logic              q_is_halt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid      <= 1'b0;
      q_mem_to_reg <= 1'b0;
      q_wr_en      <= 1'b0;
      q_mem_data   <= '0;
      q_alu_result <= '0;
      q_dst_reg    <= '0;
      q_is_halt    <= 1'b0;
    end else if (freeze) begin
      // Halted: nothing moves until reset.
    end else if (flush) begin
      // Data fields are don't-care once invalid; holding them saves enables.
      q_valid <= 1'b0;
    end else if (!stall) begin
      q_valid      <= in_valid;
      q_mem_to_reg <= in_mem_to_reg;
      q_wr_en      <= in_wr_en;
      q_mem_data   <= in_mem_data;
      q_alu_result <= in_alu_result;
      q_dst_reg    <= in_dst_reg;
      q_is_halt    <= in_is_halt;
    end
  end

endmodule

// File: rtl/cpu_wb.sv
// CPU write-back stage: MEM/WB register, write-data mux, halt FSM and an
// optional retired-instruction counter (macro WB_RETIRE_CNT_EN).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   stall, flush               pipeline control
//   memValid, WBcontrols       MEM-stage valid and {memToReg, writeEnable}
//   memData, aluResult         write-data candidates
//   dstReg, isHalt             destination index, HLT marker
//   wrData, regWriteIncomingAddr, regWriteControl   register-file write port
//   halt                       processor has retired HLT
//   retireCount                retired-instruction count (macro only)
// All outputs come from registered state only.
module cpu_wb
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              memValid,
  input  logic [1:0]        WBcontrols,
  input  logic [DATA_W-1:0] memData,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [3:0]        dstReg,
  input  logic              isHalt,
  output logic [DATA_W-1:0] wrData,
  output logic [3:0]        regWriteIncomingAddr,
  output logic              regWriteControl,
  output logic              halt
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]  retireCount
`endif
);

  wb_state_e state_q, state_d;

  logic              valid_q;
  logic              mem_to_reg_q;
  logic              wr_en_q;
  logic [DATA_W-1:0] mem_data_q;
  logic [DATA_W-1:0] alu_result_q;
  logic [3:0]        dst_reg_q;
  logic              is_halt_q;

  wb_pipe_reg #(
    .DATA_W (DATA_W)
  ) u_pipe_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .flush         (flush),
    .freeze        (state_q == HALTED),
    .in_valid      (memValid),
    .in_mem_to_reg (WBcontrols[MEMTOREG_BIT]),
    .in_wr_en      (WBcontrols[WREN_BIT]),
    .in_mem_data   (memData),
    .in_alu_result (aluResult),
    .in_dst_reg    (dstReg),
    .in_is_halt    (isHalt),
    .q_valid       (valid_q),
    .q_mem_to_reg  (mem_to_reg_q),
    .q_wr_en       (wr_en_q),
    .q_mem_data    (mem_data_q),
    .q_alu_result  (alu_result_q),
    .q_dst_reg     (dst_reg_q),
    .q_is_halt     (is_halt_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == RUN && valid_q && is_halt_q) begin
      state_d = HALTED;
    end
  end

  assign wrData               = mem_to_reg_q ? mem_data_q : alu_result_q;
  assign regWriteIncomingAddr = dst_reg_q;
  // HLT never writes, even if its control bundle says writeEnable.
  assign regWriteControl      = valid_q & wr_en_q & (dst_reg_q != 4'd0) &
                                (state_q == RUN) & ~is_halt_q;
  assign halt                 = (state_q == HALTED);

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count on the edge the instruction leaves WB; a stall keeps it in place,
  // so it is counted only once.
  always_comb begin
    cnt_d = cnt_q;
    if (valid_q && state_q == RUN && !stall && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retireCount = cnt_q;
`endif

endmodule

// File: tb/tb_cpu_wb.sv
// Directed self-checking bench for cpu_wb. Expected values are hand-derived.
module tb_cpu_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        memValid;
  logic [1:0]  WBcontrols;
  logic [15:0] memData;
  logic [15:0] aluResult;
  logic [3:0]  dstReg;
  logic        isHalt;
  logic [15:0] wrData;
  logic [3:0]  regWriteIncomingAddr;
  logic        regWriteControl;
  logic        halt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

`ifdef WB_RETIRE_CNT_EN
  logic [15:0] retireCount;
  logic [15:0] s_wrData;
  logic [3:0]  s_addr;
  logic        s_rwc;
  logic        s_halt;
  logic [3:0]  s_retireCount;
`endif

  cpu_wb #(
    .DATA_W (16),
    .CNT_W  (16)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .stall                (stall),
    .flush                (flush),
    .memValid             (memValid),
    .WBcontrols           (WBcontrols),
    .memData              (memData),
    .aluResult            (aluResult),
    .dstReg               (dstReg),
    .isHalt               (isHalt),
    .wrData               (wrData),
    .regWriteIncomingAddr (regWriteIncomingAddr),
    .regWriteControl      (regWriteControl),
    .halt                 (halt)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retireCount          (retireCount)
`endif
  );

`ifdef WB_RETIRE_CNT_EN
  cpu_wb #(
    .DATA_W (16),
    .CNT_W  (4)
  ) dut_small (
    .clk                  (clk),
    .rst_n                (rst_n),
    .stall                (stall),
    .flush                (flush),
    .memValid             (memValid),
    .WBcontrols           (WBcontrols),
    .memData              (memData),
    .aluResult            (aluResult),
    .dstReg               (dstReg),
    .isHalt               (isHalt),
    .wrData               (s_wrData),
    .regWriteIncomingAddr (s_addr),
    .regWriteControl      (s_rwc),
    .halt                 (s_halt),
    .retireCount          (s_retireCount)
  );
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] ctl, input logic [15:0] md,
                       input logic [15:0] alu, input logic [3:0] dst, input logic hlt);
    memValid   = v;
    WBcontrols = ctl;
    memData    = md;
    aluResult  = alu;
    dstReg     = dst;
    isHalt     = hlt;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 2'b00, 16'h0, 16'h0, 4'd0, 1'b0);
    #12;
    check("rst_rwc", 32'(regWriteControl), 32'd0);
    check("rst_wr", 32'(wrData), 32'd0);
    check("rst_addr", 32'(regWriteIncomingAddr), 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    rst_n = 1'b1;
    #1;

    // Capture and mux
    drive(1'b1, 2'b01, 16'h0000, 16'h1234, 4'd3, 1'b0);
    step();
    check("cap_rwc", 32'(regWriteControl), 32'd1);
    check("cap_addr", 32'(regWriteIncomingAddr), 32'd3);
    check("cap_wr", 32'(wrData), 32'h1234);
    drive(1'b1, 2'b11, 16'hBEEF, 16'h1234, 4'd3, 1'b0);
    step();
    check("mux_mem", 32'(wrData), 32'hBEEF);
    check("mux_rwc", 32'(regWriteControl), 32'd1);

    // R0 suppression
    drive(1'b1, 2'b01, 16'hBEEF, 16'h5555, 4'd0, 1'b0);
    step();
    check("r0_rwc", 32'(regWriteControl), 32'd0);
    check("r0_wr", 32'(wrData), 32'h5555);

    // Stall holds
    drive(1'b1, 2'b01, 16'h0000, 16'hA5A5, 4'd5, 1'b0);
    step();
    check("r5_rwc", 32'(regWriteControl), 32'd1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b11, 16'h1111 * 16'(i + 1), 16'h0F0F, 4'd7, 1'b0);
      step();
      check("stall_wr", 32'(wrData), 32'hA5A5);
      check("stall_addr", 32'(regWriteIncomingAddr), 32'd5);
      check("stall_rwc", 32'(regWriteControl), 32'd1);
    end

    // Flush wins over stall
    flush = 1'b1;
    step();
    check("flush_rwc", 32'(regWriteControl), 32'd0);
    flush = 1'b0;
    stall = 1'b0;

    // memValid=0 gives no write
    drive(1'b0, 2'b01, 16'h0, 16'h2222, 4'd2, 1'b0);
    step();
    check("inv_rwc", 32'(regWriteControl), 32'd0);

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b01, 16'h0, 16'h3000 + 16'(i), 4'(8 + i), 1'b0);
      step();
      check("wr_seq_addr", 32'(regWriteIncomingAddr), 32'(8 + i));
      check("wr_seq_rwc", 32'(regWriteControl), 32'd1);
    end

    // Halt
    drive(1'b1, 2'b01, 16'h0, 16'h4444, 4'd4, 1'b1);
    step();
    check("hlt_nowr", 32'(regWriteControl), 32'd0);
    check("hlt_notyet", 32'(halt), 32'd0);
    drive(1'b1, 2'b01, 16'h0, 16'h6666, 4'd6, 1'b0);
    step();
    check("halted", 32'(halt), 32'd1);
    check("halted_rwc", 32'(regWriteControl), 32'd0);
    check("halted_wr", 32'(wrData), 32'h6666);
    drive(1'b1, 2'b01, 16'h0, 16'h7777, 4'd7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      step();
      check("frz_halt", 32'(halt), 32'd1);
      check("frz_rwc", 32'(regWriteControl), 32'd0);
      check("frz_wr", 32'(wrData), 32'h6666);
    end
    flush = 1'b0;
`ifdef WB_RETIRE_CNT_EN
    check("cnt_pre_rst", 32'(retireCount), 32'd7);
`endif

    // Asynchronous reset mid-cycle while halted
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_halt", 32'(halt), 32'd0);
    check("arst_rwc", 32'(regWriteControl), 32'd0);
    check("arst_wr", 32'(wrData), 32'd0);
`ifdef WB_RETIRE_CNT_EN
    check("arst_cnt", 32'(retireCount), 32'd0);
`endif
    #2;
    rst_n = 1'b1;
    drive(1'b1, 2'b01, 16'h0, 16'h9999, 4'd9, 1'b0);
    step();
    check("post_rst_rwc", 32'(regWriteControl), 32'd1);
    check("post_rst_wr", 32'(wrData), 32'h9999);

`ifdef WB_RETIRE_CNT_EN
    // I1 captured above; I2..I5 follow, I3 stalled for two edges.
    drive(1'b1, 2'b01, 16'h0, 16'h0002, 4'd2, 1'b0);
    step();
    drive(1'b1, 2'b01, 16'h0, 16'h0003, 4'd3, 1'b0);
    step();
    stall = 1'b1;
    step();
    step();
    stall = 1'b0;
    drive(1'b1, 2'b01, 16'h0, 16'h0004, 4'd4, 1'b0);
    step();
    drive(1'b1, 2'b01, 16'h0, 16'h0005, 4'd5, 1'b0);
    step();
    drive(1'b0, 2'b00, 16'h0, 16'h0, 4'd0, 1'b0);
    step();
    check("cnt_five", 32'(retireCount), 32'd5);
    check("cnt_small_five", 32'(s_retireCount), 32'd5);
    drive(1'b1, 2'b01, 16'h0, 16'h0001, 4'd1, 1'b0);
    for (int i = 0; i < 20; i++) step();
    drive(1'b0, 2'b00, 16'h0, 16'h0, 4'd0, 1'b0);
    step();
    check("cnt_25", 32'(retireCount), 32'd25);
    check("cnt_sat", 32'(s_retireCount), 32'hF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_wb.md
CPU_WB -- requirements
Module: cpu_WB

Interface
REQ-001 Parameter DATA_W, default 16, register/datapath width.
REQ-002 Parameter CNT_W, default 16, retired-instruction counter width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 stall  input  1  hold the MEM/WB register contents.
REQ-006 flush  input  1  invalidate the incoming MEM-stage instruction.
REQ-007 memValid  input  1  the MEM stage holds a real instruction.
REQ-008 WBcontrols  input  2  {memToReg, writeEnable}, the decode-generated bundle after travelling through EX/MEM.
REQ-009 memData  input  DATA_W  load data from data memory.
REQ-010 aluResult  input  DATA_W  EX result, including PCS value and LLB/LHB merge.
REQ-011 dstReg  input  4  destination register index.
REQ-012 isHalt  input  1  the MEM-stage instruction is HLT.
REQ-013 wrData  output  DATA_W  register-file write data sent to decode.
REQ-014 regWriteIncomingAddr  output  4  register-file write index sent to decode.
REQ-015 regWriteControl  output  1  register-file write enable sent to decode.
REQ-016 halt  output  1  the processor has retired HLT.
REQ-017 retireCount  output  CNT_W  count of retired instructions; present only with the configuration macro.

Function
REQ-018 The MEM/WB register shall capture the fields memToReg, writeEnable, memData, aluResult, dstReg and isHalt, plus a valid bit.
REQ-019 Capture rule: when stall=0 and flush=0, the register shall load all fields and set valid=memValid.
REQ-020 Flush rule: when flush=1, valid shall clear to 0 on the next edge. Flush wins over stall. The data fields are don't-care.
REQ-021 Stall rule: when stall=1 and flush=0, all fields and valid shall hold.
REQ-022 Latency: an instruction presented at edge N shall drive the write port during cycle N+1. This is exactly one cycle.
REQ-023 wrData shall equal the registered memData when memToReg=1, otherwise the registered aluResult.
REQ-024 regWriteIncomingAddr shall equal the registered dstReg.
REQ-025 regWriteControl shall equal valid & writeEnable & (dstReg != 0) & (state == RUN). Writes to R0 are suppressed.
REQ-026 All outputs shall be driven combinationally from registered state only. There shall be no input-to-output combinational path.
REQ-027 The halt FSM shall have two states, RUN and HALTED.
REQ-028 In RUN, when valid & isHalt is registered, the FSM shall move to HALTED on the next edge. The HLT instruction itself shall perform no register write.
REQ-029 In HALTED, halt shall be 1, the MEM/WB register shall freeze regardless of stall, flush or memValid, and regWriteControl shall be 0.
REQ-030 HALTED shall be left only by reset.
REQ-031 A stalled HLT that is flushed before capture shall not halt.

Reset
REQ-032 rst_n=0 shall asynchronously clear valid, all registered fields, state (to RUN), halt and retireCount.
REQ-033 After reset, regWriteControl=0, wrData=0, regWriteIncomingAddr=0 and halt=0.
REQ-034 Reset asserted mid-stall or in HALTED shall take effect immediately. The first capture shall happen on the first edge after deassertion.

Configuration
REQ-035 With macro WB_RETIRE_CNT_EN defined: retireCount shall increment by 1 on each edge where valid=1, state=RUN and stall=0, including for HLT.
REQ-036 retireCount shall saturate at all-ones.
REQ-037 A stalled instruction shall be counted once.
REQ-038 Without WB_RETIRE_CNT_EN: the retireCount port, counter logic and associated state shall be absent. All other behaviour shall be identical.

Structure
REQ-039 A shared package (cpu_pkg) shall hold:
- the WBcontrols bit positions (MEMTOREG_BIT=1, WREN_BIT=0);
- the halt-FSM state encoding (RUN, HALTED);
- the HLT opcode constant 4'hF.
REQ-040 One sub-module, wb_pipe_reg, shall implement the MEM/WB register with stall, flush and freeze. The mux and FSM shall live in cpu_WB.

Verification
REQ-041 Capture and mux:
- Stimulus: memValid=1, WBcontrols=2'b01, aluResult=16'h1234, dstReg=3, stall=0.
- Required next cycle: regWriteControl=1, regWriteIncomingAddr=3, wrData=16'h1234.
- Stimulus: WBcontrols=2'b11, memData=16'hBEEF.
- Required next cycle: wrData=16'hBEEF.
REQ-042 R0 suppression:
- Stimulus: valid write with dstReg=0.
- Required: regWriteControl=0 and wrData still shows the mux output.
REQ-043 Stall and flush:
- Stimulus: capture a write to R5, then stall=1 for 3 cycles while the inputs change.
- Required: outputs hold R5's data throughout.
- Stimulus: assert flush=1 together with stall=1.
- Required next cycle: regWriteControl=0.
REQ-044 Halt:
- Stimulus: memValid=1, isHalt=1, WBcontrols=2'b01.
- Required: no write in the following cycle, then halt=1.
- Stimulus: later valid writes.
- Required: regWriteControl stays 0 until rst_n=0.
REQ-045 Reset:
- Stimulus: rst_n=0 pulsed asynchronously mid-cycle while HALTED and retireCount=7.
- Required: halt=0, retireCount=0 and regWriteControl=0 immediately, before the next clock edge.
REQ-046 Counter (WB_RETIRE_CNT_EN):
- Stimulus: 5 valid instructions, one of them stalled for 2 cycles.
- Required: retireCount=5.
- Stimulus: preload the counter near all-ones with CNT_W=4.
- Required: retireCount saturates at 4'hF.
